rnn_seq_master: RTL

- Host-side sequencer that drives the RNN accelerator's register port (read/write/addr/32-bit data) as bus master.
- Consumes a stream of per-character embedding words and writes each character's input vector (addr 1), then starts the cell (addr 0 write) and polls until the cell is idle (addr 1 read).
- After the last character it triggers the dense layer (addr 7 write), polls for a valid result (addr 0 read), reads the result (addr 7 read) and presents it on a valid/ready result port.
- Sits between a DMA or stream source and the accelerator instance, so the CPU no longer bit-bangs the protocol.

---
 rtl/rnn_pkg.sv | 32 +++
 rtl/rnn_poll_timer.sv | 26 ++
 rtl/rnn_seq_master.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rnn_pkg.sv
// rnn_pkg: shared register map, status semantics and master state encoding for the RNN sequencer
package rnn_pkg;

   localparam logic [2:0] ADDR_START   = 3'd0;
   localparam logic [2:0] ADDR_INPUT   = 3'd1;
   localparam logic [2:0] ADDR_W       = 3'd2;
   localparam logic [2:0] ADDR_U       = 3'd3;
   localparam logic [2:0] ADDR_RB      = 3'd4;
   localparam logic [2:0] ADDR_DENSE_W = 3'd5;
   localparam logic [2:0] ADDR_DENSE_B = 3'd6;
   localparam logic [2:0] ADDR_RESULT  = 3'd7;

   // reading addr 0 returns the dense VALID flag in bit 0; reading addr 1 returns the cell LOAD (idle) flag in bit 0
   localparam logic [2:0] STAT_VALID = ADDR_START;
   localparam logic [2:0] STAT_LOAD  = ADDR_INPUT;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_EMB,
      S_START,
      S_POLL_LOAD,
      S_DENSE,
      S_POLL_VALID,
      S_READ_RES,
      S_OUT
   } state_e;

   function automatic logic [31:0] wr_word(input logic [7:0] row, input logic [7:0] idx, input logic [15:0] val);
      return {row, idx, val};
   endfunction

endpackage

// File: rtl/rnn_poll_timer.sv
// rnn_poll_timer: counts poll reads and flags the read that exhausts the poll budget
module rnn_poll_timer #(
   parameter int POLL_MAX = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic timeout_o
);

   localparam int CW = $clog2(POLL_MAX + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // a clear wins over counting, so a completing read never advances the count
   always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;

   // poll read counter
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;

   assign timeout_o = en_i && !clr_i && (cnt_q == CW'(POLL_MAX - 1));

endmodule

// File: rtl/rnn_seq_master.sv
// rnn_seq_master: streams embedding words into the RNN accelerator and returns the dense result
import rnn_pkg::*;

module rnn_seq_master #(
   parameter int EMB_LEN  = 4,
   parameter int POLL_MAX = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic        in_last,
   output logic        m_read,
   output logic        m_write,
   output logic [2:0]  m_addr,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_data,
   output logic        busy,
   output logic        err
);

   localparam logic [7:0] IDX_LAST = 8'(EMB_LEN - 1);

   state_e      state_q, state_d;
   logic [7:0]  idx_q, idx_d;
   logic        last_q, last_d;
   logic        err_q, err_d;
   logic        res_valid_q, res_valid_d;
   logic [15:0] res_data_q, res_data_d;
   logic        poll_en, poll_clr, timeout;
   logic        unused_rd;

   assign unused_rd = ^m_readdata[31:16];
   assign poll_en   = (state_q == S_POLL_LOAD) || (state_q == S_POLL_VALID);
   assign poll_clr  = !poll_en || m_readdata[0];

   rnn_poll_timer #(.POLL_MAX(POLL_MAX)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (poll_clr),
      .en_i     (poll_en),
      .timeout_o(timeout)
   );

   // next state and bus strobes; strobes are combinational so each write lands in the cycle it is decided
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      last_d      = last_q;
      err_d       = err_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      in_ready    = 1'b0;
      m_read      = 1'b0;
      m_write     = 1'b0;
      m_addr      = 3'd0;
      m_writedata = 32'd0;
      case (state_q)
         S_IDLE: state_d = in_valid ? S_LOAD_EMB : S_IDLE;
         S_LOAD_EMB: begin
            in_ready = 1'b1;
            if (in_valid) begin
               m_write     = 1'b1;
               m_addr      = ADDR_INPUT;
               m_writedata = wr_word(8'h00, idx_q, in_data);
               last_d      = last_q | in_last;
               idx_d       = (idx_q == IDX_LAST) ? 8'd0 : idx_q + 8'd1;
               state_d     = (idx_q == IDX_LAST) ? S_START : S_LOAD_EMB;
            end
         end
         S_START: begin
            m_write = 1'b1;
            m_addr  = ADDR_START;
            state_d = S_POLL_LOAD;
         end
         S_POLL_LOAD: begin
            m_read = 1'b1;
            m_addr = STAT_LOAD;
            if (m_readdata[0]) state_d = last_q ? S_DENSE : S_LOAD_EMB;
            else if (timeout) begin
               err_d   = 1'b1;
               idx_d   = 8'd0;
               last_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_DENSE: begin
            m_write = 1'b1;
            m_addr  = ADDR_RESULT;
            last_d  = 1'b0;
            state_d = S_POLL_VALID;
         end
         S_POLL_VALID: begin
            m_read = 1'b1;
            m_addr = STAT_VALID;
            if (m_readdata[0]) state_d = S_READ_RES;
            else if (timeout) begin
               err_d   = 1'b1;
               idx_d   = 8'd0;
               last_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_READ_RES: begin
            m_read      = 1'b1;
            m_addr      = ADDR_RESULT;
            res_data_d  = m_readdata[15:0];
            res_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            res_valid_d = res_ready ? 1'b0 : 1'b1;
            state_d     = res_ready ? S_IDLE : S_OUT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // sequencer state; reset aborts immediately without touching the accelerator
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= 8'd0;
         last_q      <= 1'b0;
         err_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         err_q       <= err_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign err       = err_q;
   assign busy      = state_q != S_IDLE;

endmodule
